native_mem_arbiter: RTL
=======================

# native_mem_arbiter

Parametrised N-to-1 arbiter for the PicoRV32 native memory interface. It lets several bus masters share one slave: the CPU, a program loader or debug monitor, and later DMA. The slave is a bram_controller or a peripheral. It replaces ad-hoc 2:1 muxing of a monitor port onto the RAM with a synthesisable block that offers fixed-priority or round-robin grant and a per-transaction timeout that frees the bus if the slave never responds.

## Interface
- NUM_MASTERS, 2: number of master ports, 2..8.
- ARB_MODE, 1: 0 = fixed priority (index 0 highest), 1 = round-robin.
- TIMEOUT_CYCLES, 0: slave-response timeout in cycles counted from s_valid rise; 0 disables the timeout.
- TIMEOUT_RDATA, 32'hDEAD_BEEF: read data returned to the master on timeout.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- m_valid  in  [NUM_MASTERS]  per-master request.
- m_instr  in  [NUM_MASTERS]  per-master instruction-fetch flag.
- m_addr  in  [NUM_MASTERS][32]  per-master byte address.
- m_wdata  in  [NUM_MASTERS][32]  per-master write data.
- m_wstrb  in  [NUM_MASTERS][4]  per-master byte strobes; 0 = read.
- m_ready  out  [NUM_MASTERS]  per-master one-cycle completion pulse.
- m_rdata  out  32  read data, shared by all masters; valid only with the owning m_ready bit.
- s_valid, s_instr  out  1  request to the slave.
- s_addr, s_wdata  out  32  request address and write data to the slave.
- s_wstrb  out  4  request byte strobes to the slave.
- s_ready  in  1  slave completion.
- s_rdata  in  32  slave read data.
- grant_id  out  $clog2(NUM_MASTERS)  index of the current owner.
- busy  out  1  high while in GRANT.
- timeout_err  out  1  one-cycle pulse when a transaction is aborted.

## Operation
- States are IDLE and GRANT.
- IDLE:
  - The picker chooses a winner among asserted m_valid.
  - The winner index is registered into grant_id, the timeout counter clears, and the state moves to GRANT.
  - No m_valid asserted: stay in IDLE.
- GRANT:
  - s_valid = m_valid[grant_id].
  - s_instr, s_addr, s_wdata and s_wstrb are a combinational mux of the grant_id master.
  - Non-owners see m_ready = 0 and wait. Their requests are held, never dropped.
- Completion: s_ready high in GRANT.
  - m_ready[grant_id] = 1 and m_rdata = s_rdata in the same cycle.
  - The state returns to IDLE.
  - Round-robin: the priority pointer becomes grant_id+1, wrapping NUM_MASTERS-1 to 0.
- Timeout: TIMEOUT_CYCLES > 0 and the counter reaches TIMEOUT_CYCLES with no s_ready.
  - m_ready[grant_id] = 1, m_rdata = TIMEOUT_RDATA, timeout_err = 1, all for one cycle.
  - s_valid drops and the state returns to IDLE. The pointer advances as on completion.
- Owner drops m_valid before s_ready: the transaction is abandoned, the state returns to IDLE, no m_ready is issued, and the pointer is unchanged.
- s_ready while in IDLE is ignored. Slaves must not complete a request after s_valid has dropped.
- Fixed priority: the lowest asserted index always wins, so starvation is permitted.
- Round-robin: the search starts at the pointer and wraps. Any requester is served within NUM_MASTERS grants.
- Reset values: state IDLE, pointer 0, grant_id 0, counter 0. Outputs: busy 0, s_valid 0, m_ready all 0, timeout_err 0, m_rdata 0.
- Reset mid-transaction aborts with no m_ready pulse.

## Timing
- Arbitration latency: s_valid rises 1 cycle after m_valid is first sampled in IDLE.
- Response latency: the slave-to-master path is combinational, so m_ready is in the same cycle as s_ready.
- Masters must deassert m_valid, or present a new request, no later than the cycle after m_ready.
- There is a minimum 1-cycle IDLE gap between consecutive grants, so back-to-back throughput is 1 transaction per (slave latency + 2) cycles.
- Timeout fires on the edge where the counter equals TIMEOUT_CYCLES, i.e. TIMEOUT_CYCLES cycles after s_valid rose.
- m_valid changing in IDLE is sampled only at the clock edge; there is no combinational grant.

## Structure
- Package native_mem_pkg holds:
  - typedef enum arb_state_e {IDLE, GRANT};
  - typedef enum arb_mode_e {ARB_FIXED, ARB_RR};
  - constant NATIVE_TIMEOUT_RDATA.
- Sub-module rr_picker: combinational, parametrised N.
  - Inputs: req and start pointer.
  - Outputs: winner index and any_req.
  - Fixed-priority mode drives the start pointer to 0.

## Test plan
- Single master: M0 writes 0x1E to 0x80, then reads it back. Expect s_valid 1 cycle after m_valid, m_ready[0] on s_ready, read returns 0x1E, timeout_err never asserted.
- Simultaneous requests, ARB_MODE=1, 2 masters, 8 continuous requests each. Expect grant_id sequence 0,1,0,1,… and exactly 8 m_ready pulses per master.
- ARB_MODE=0: M0 and M1 request continuously. Expect M1 to get no grant. When M0 goes idle, M1 is granted the next cycle.
- TIMEOUT_CYCLES=8, slave ready tied low. Expect m_ready[0], m_rdata=0xDEADBEEF and a single timeout_err pulse 8 cycles after s_valid rose. busy returns to 0.
- reset_n pulled low during GRANT. Expect all outputs at reset values immediately, no m_ready, and the first grant after release goes to master 0.
- NUM_MASTERS=3: a CPU fetch with m_instr=1 on M2 plus a loader on M0. Expect s_instr=1 only while grant_id=2, and a program loaded by M0 to be fetched correctly by M2.

Source files
------------

// File: rtl/native_mem_pkg.sv
// rtl/native_mem_pkg.sv - shared types and constants for the native memory arbiter
package native_mem_pkg;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;

    typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;

    localparam logic [31:0] NATIVE_TIMEOUT_RDATA = 32'hDEAD_BEEF;

    // Index after idx, wrapping n-1 back to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational rotating-priority request picker
//
// Searches req starting at index 'start', wrapping at N-1, and reports the first
// asserted request. Fixed priority is obtained by tying start to 0.
//   req      in   [N]   request vector
//   start    in   [IW]  index given highest priority
//   winner   out  [IW]  index of the chosen request (start when none)
//   any_req  out  1     at least one request asserted
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [IW-1:0] winner,
    output logic          any_req
);

    logic [IW-1:0] idx;

    // Walk from the farthest candidate back to 'start' so the nearest one wins.
    always_comb begin
        winner  = start;
        any_req = 1'b0;
        idx     = start;
        for (int i = N - 1; i >= 0; i--) begin
            idx = IW'((int'(start) + i) % N);
            if (req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/native_mem_arbiter.sv
// rtl/native_mem_arbiter.sv - N-to-1 arbiter for the PicoRV32 native memory interface
//
// Masters share one slave; a grant is held until the slave completes, the owner
// withdraws, or the optional response timeout expires.
//   clk, reset_n                        clock, asynchronous active-low reset
//   m_valid/m_instr/m_addr/m_wdata/m_wstrb  per-master requests
//   m_ready, m_rdata                    per-master completion pulse, shared read data
//   s_valid/s_instr/s_addr/s_wdata/s_wstrb  request forwarded to the slave
//   s_ready, s_rdata                    slave completion and read data
//   grant_id, busy, timeout_err         current owner, GRANT state, abort pulse
module native_mem_arbiter
    import native_mem_pkg::*;
#(
    parameter int          NUM_MASTERS    = 2,
    parameter int          ARB_MODE       = 1,
    parameter int          TIMEOUT_CYCLES = 0,
    parameter logic [31:0] TIMEOUT_RDATA  = NATIVE_TIMEOUT_RDATA
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic [NUM_MASTERS-1:0]             m_valid,
    input  logic [NUM_MASTERS-1:0]             m_instr,
    input  logic [NUM_MASTERS-1:0][31:0]       m_addr,
    input  logic [NUM_MASTERS-1:0][31:0]       m_wdata,
    input  logic [NUM_MASTERS-1:0][3:0]        m_wstrb,
    output logic [NUM_MASTERS-1:0]             m_ready,
    output logic [31:0]                        m_rdata,
    output logic                               s_valid,
    output logic                               s_instr,
    output logic [31:0]                        s_addr,
    output logic [31:0]                        s_wdata,
    output logic [3:0]                         s_wstrb,
    input  logic                               s_ready,
    input  logic [31:0]                        s_rdata,
    output logic [$clog2(NUM_MASTERS)-1:0]     grant_id,
    output logic                               busy,
    output logic                               timeout_err
);

    localparam int   IW      = $clog2(NUM_MASTERS);
    localparam int   CW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic USE_TMO = (TIMEOUT_CYCLES > 0);
    localparam logic RR_MODE = (ARB_MODE == int'(ARB_RR));

    arb_state_e    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] pick_start, pick_winner, ptr_next;
    logic          pick_any, owner_valid, tmo_hit;

    assign pick_start = RR_MODE ? ptr_q : '0;

    rr_picker #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_picker (
        .req     (m_valid),
        .start   (pick_start),
        .winner  (pick_winner),
        .any_req (pick_any)
    );

    assign owner_valid = m_valid[grant_q];
    assign tmo_hit     = USE_TMO && (cnt_q == CW'(TIMEOUT_CYCLES));
    assign ptr_next    = IW'(wrap_inc(int'(grant_q), NUM_MASTERS));

    // Request path is a plain mux of the owner; only s_valid is gated by state.
    assign s_instr  = m_instr[grant_q];
    assign s_addr   = m_addr[grant_q];
    assign s_wdata  = m_wdata[grant_q];
    assign s_wstrb  = m_wstrb[grant_q];
    assign grant_id = grant_q;
    assign busy     = (state_q == GRANT);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        s_valid     = 1'b0;
        m_ready     = '0;
        m_rdata     = '0;
        timeout_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    grant_d = pick_winner;
                    cnt_d   = '0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                // The timeout cycle withdraws s_valid so the slave cannot also complete it.
                s_valid = owner_valid && !tmo_hit;
                if (!owner_valid) begin
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    m_ready[grant_q] = 1'b1;
                    m_rdata          = TIMEOUT_RDATA;
                    timeout_err      = 1'b1;
                    ptr_d            = ptr_next;
                    state_d          = IDLE;
                end else if (s_ready) begin
                    m_ready[grant_q] = 1'b1;
                    m_rdata          = s_rdata;
                    ptr_d            = ptr_next;
                    state_d          = IDLE;
                end else if (USE_TMO) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
